// File: rtl/alu_iter.sv
// Registered EX-stage ALU with an iterative shift-add multiplier and restoring divider.
// Multi-cycle ops raise busy for WIDTH+1 cycles and write the HI/LO pair at the end.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             less,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_CLZ   = 4'd8;
  localparam logic [3:0] OP_CLO   = 4'd9;
  localparam logic [3:0] OP_MULT  = 4'd10;
  localparam logic [3:0] OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  function automatic logic [WIDTH-1:0] clz(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        hit = 1'b1;
      end else if (!hit) begin
        n = n + ONE;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  function automatic logic is_multi(input logic [3:0] o);
    return (o >= OP_MULT) && (o <= OP_DIVU);
  endfunction

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_hold;
  logic               is_div, neg_a, neg_x, dbz;

  logic [WIDTH-1:0]   sum, diff, simple_res, mag_a, mag_b;
  logic               slt, sltu, simple_ovf, signed_op, sa, sb;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   trial, sub;
  logic [2*WIDTH-1:0] iter_next, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = $signed(a) < $signed(b);
  assign sltu = a < b;

  // Single-cycle result and signed-overflow flag for the simple ops
  always_comb begin
    simple_res = '0;
    simple_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        simple_res = sum;
        simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res = diff;
        simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_XOR:  simple_res = a ^ b;
      OP_NOR:  simple_res = ~(a | b);
      OP_SLT:  simple_res = slt ? ONE : '0;
      OP_SLTU: simple_res = sltu ? ONE : '0;
      OP_CLZ:  simple_res = clz(a);
      OP_CLO:  simple_res = clz(~a);
      OP_MFHI: simple_res = hi;
      OP_MFLO: simple_res = lo;
      default: simple_res = '0;
    endcase
  end

  // Operand magnitudes and sign bookkeeping at capture time
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sa        = signed_op && a[WIDTH-1];
    sb        = signed_op && b[WIDTH-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    trial   = {1'b0, acc[2*WIDTH-1:WIDTH-1]};
    sub     = trial - {2'b00, operand};
    if (!is_div) begin
      iter_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (sub[WIDTH+1]) begin
      iter_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      iter_next = {sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction of the magnitude result into HI/LO form
  always_comb begin
    prod = neg_x ? -acc : acc;
    if (!is_div) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (dbz) begin
      fix_hi = a_hold;
      fix_lo = '1;
    end else begin
      fix_hi = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_x ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && is_multi(op)) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_next = FIX;
        end else begin
          state_next = RUN;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath, HI/LO and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      zero        <= 1'b0;
      less        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      operand     <= '0;
      a_hold      <= '0;
      is_div      <= 1'b0;
      neg_a       <= 1'b0;
      neg_x       <= 1'b0;
      dbz         <= 1'b0;
    end else begin
      busy        <= (state_next != IDLE);
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_multi(op)) begin
            is_div  <= (op == OP_DIV) || (op == OP_DIVU);
            neg_a   <= sa;
            neg_x   <= sa ^ sb;
            dbz     <= ((op == OP_DIV) || (op == OP_DIVU)) && (b == '0);
            a_hold  <= a;
            cnt     <= '0;
            if ((op == OP_DIV) || (op == OP_DIVU)) begin
              acc     <= {{WIDTH{1'b0}}, mag_a};
              operand <= mag_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, mag_b};
              operand <= mag_a;
            end
          end else if (start) begin
            result   <= simple_res;
            zero     <= (simple_res == '0);
            less     <= (op == OP_SLTU) ? sltu : slt;
            overflow <= simple_ovf;
            done     <= 1'b1;
          end else begin
            done <= 1'b0;
          end
        end
        RUN: begin
          acc <= iter_next;
          cnt <= cnt + CNT_ONE;
        end
        FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          result      <= fix_lo;
          zero        <= (fix_lo == '0);
          less        <= 1'b0;
          overflow    <= 1'b0;
          div_by_zero <= dbz;
          done        <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=32 and WIDTH=16.
module tb_alu_iter;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd6, OP_SLTU = 4'd7;
  localparam logic [3:0] OP_CLZ = 4'd8, OP_CLO = 4'd9, OP_MULT = 4'd10, OP_MULTU = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_MFHI = 4'd14, OP_MFLO = 4'd15;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  op;
  logic [31:0] a, b, result, hi, lo;
  logic        busy, done, zero, less, overflow, div_by_zero;

  logic        start16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, result16, hi16, lo16;
  logic        busy16, done16, zero16, less16, overflow16, dbz16;

  int checks   = 0;
  int failures = 0;
  int lat, bcnt, dcnt;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
    .zero(zero), .less(less), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  alu_iter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .hi(hi16), .lo(lo16),
    .zero(zero16), .less(less16), .overflow(overflow16), .div_by_zero(dbz16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue a multi-cycle op and wait (bounded) for done; counts busy samples
  task automatic run_long(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int l, output int bc);
    issue(o, x, y);
    l = 0; bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    start16 = 1'b0; op16 = 4'd0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);

    // reset wins over a simultaneous start
    op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio_done", 32'(done), 32'd0);
    chk("rst_prio_result", result, 32'd0);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add_done", 32'(done), 32'd1);
    chk("add_busy", 32'(busy), 32'd0);
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf", 32'(overflow), 32'd1);
    issue(OP_SUB, 32'd3, 32'd5);
    chk("sub_done", 32'(done), 32'd1);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_less", 32'(less), 32'd1);
    chk("sub_ovf", 32'(overflow), 32'd0);

    issue(OP_CLZ, 32'h0001_0000, 32'd0);
    chk("clz_16", result, 32'd15);
    issue(OP_CLZ, 32'd0, 32'd0);
    chk("clz_zero", result, 32'd32);
    issue(OP_CLO, 32'hFFFF_FFFF, 32'd0);
    chk("clo_ones", result, 32'd32);
    issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF);
    chk("sltu", result, 32'd1);
    chk("sltu_less", 32'(less), 32'd1);
    issue(OP_SLT, 32'd1, 32'hFFFF_FFFF);
    chk("slt", result, 32'd0);
    chk("slt_zero", 32'(zero), 32'd1);
    chk("slt_less", 32'(less), 32'd0);

    // signed multiply with an ADD pulsed while busy
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_e0", 32'(busy), 32'd1);
    chk("mult_done_e0", 32'(done), 32'd0);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == 9) begin
        op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("mult_latency", 32'(lat), 32'd33);
    chk("mult_busy_cycles", 32'(bcnt), 32'd33);
    chk("mult_busy_done", 32'(busy), 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("mult_result", result, 32'hFFFF_FFF1);
    issue(OP_MFHI, 32'd0, 32'd0);
    chk("mfhi_done", 32'(done), 32'd1);
    chk("mfhi_result", result, 32'hFFFF_FFFF);

    run_long(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
    chk("divu_latency", 32'(lat), 32'd33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_result", result, 32'd14);
    run_long(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_long(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("div_min_lo", lo, 32'h8000_0000);
    chk("div_min_hi", hi, 32'd0);
    chk("div_min_dbz", 32'(div_by_zero), 32'd0);

    run_long(OP_DIV, 32'd5, 32'd0, lat, bcnt);
    chk("dbz_latency", 32'(lat), 32'd33);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);
    chk("dbz_hi", hi, 32'd5);
    chk("dbz_flag", 32'(div_by_zero), 32'd1);
    @(posedge clk); #1;
    chk("dbz_flag_after", 32'(div_by_zero), 32'd0);
    chk("dbz_done_after", 32'(done), 32'd0);

    // reset ten cycles into a MULTU
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0);
    chk("abort_mflo_done", 32'(done), 32'd1);
    chk("abort_mflo", result, 32'd0);

    // WIDTH=16 unsigned multiply
    op16 = OP_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_latency", 32'(lat), 32'd17);
    chk("w16_hi", 32'(hi16), 32'h0000_FFFE);
    chk("w16_lo", 32'(lo16), 32'h0000_0001);
    chk("w16_result", 32'(result16), 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, registered ALU with an iterative multiply/divide unit and HI/LO result registers. It extends the combinational single-cycle ALU in three ways:
- generic `WIDTH`;
- a start/busy/done handshake;
- multi-cycle signed/unsigned MULT/DIV alongside the existing arithmetic, logic, compare and count-leading-bits operations.

It sits in the EX stage. The pipeline controller stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Legal values are even and ≥ 8.

Ports:
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: operation request. Sampled only when `busy`=0.
- `op` input, 4 bits: operation code.
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU
  - 8 CLZ, 9 CLO, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO
- `a` input, `WIDTH` bits: operand A. Sampled with `start`.
- `b` input, `WIDTH` bits: operand B. Sampled with `start`.
- `busy` output, 1 bit: a multi-cycle operation is in progress.
- `done` output, 1 bit: one-cycle pulse; `result` and flags are valid.
- `result` output, `WIDTH` bits: registered result. Holds until the next `done`.
- `hi` output, `WIDTH` bits: HI register.
  - After MULT/MULTU: product high half.
  - After DIV/DIVU: remainder.
- `lo` output, `WIDTH` bits: LO register.
  - After MULT/MULTU: product low half.
  - After DIV/DIVU: quotient.
- `zero` output, 1 bit: `result` == 0.
- `less` output, 1 bit: a < b, signed. SLTU uses an unsigned compare. Forced to 0 for ops 10–13.
- `overflow` output, 1 bit: signed overflow on ADD/SUB. 0 for all other ops.
- `div_by_zero` output, 1 bit: set with `done` for a DIV/DIVU whose `b` is 0. Otherwise 0.

## Operation
- Reset sets every output to 0, sets `hi`/`lo` to 0 and sets the FSM to IDLE.
  - Reset in any state aborts the operation.
  - No `done` is issued for the aborted operation.
- FSM states:
  - IDLE: accept a request.
  - RUN: iterate; a counter runs from 0 to `WIDTH`-1.
  - FIX: sign correction and HI/LO write.
- Simple ops (0–9, 14, 15) complete in IDLE and never raise `busy`.
  - ADD/SUB are modulo 2^`WIDTH`.
  - NOR is the bitwise NOT of (a|b).
  - SLT/SLTU set `result` to 1 when the compare is true, else 0.
  - CLZ counts leading zeros of `a`; CLO counts leading ones of `a`. Both return `WIDTH` for an all-zeros or all-ones input respectively.
  - MFHI/MFLO copy `hi`/`lo`. HI/LO are never modified by simple ops.
- MULT/MULTU: shift-add over operand magnitudes, one bit per RUN cycle.
  - FIX negates the 2·`WIDTH` product when exactly one operand of a signed MULT is negative.
  - `result` = new `lo`.
- DIV/DIVU: restoring division over magnitudes, one quotient bit per RUN cycle.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives `lo` = most-negative, `hi` = 0.
  - Divide by zero still takes full latency, and gives `lo` = all ones, `hi` = `a`, `div_by_zero` = 1.
  - `result` = new `lo`.
- `start` while `busy`=1 is ignored and is not queued.
- Operands are captured internally. Changing `a`/`b`/`op` during RUN has no effect.

## Timing
- Let E0 be the edge that samples `start`=1 with `busy`=0.
- Simple op: at E0 the result and flags are registered, and `done`=1 for the following cycle.
  - Back-to-back simple ops are legal every cycle; `done` then stays high continuously.
- MULT/DIV:
  - `busy` rises at E0.
  - Iterations occur on edges E1..E`WIDTH`.
  - FIX occurs on edge E(`WIDTH`+1). At that edge `hi`/`lo`/`result`/flags update, `busy` falls and `done`=1 for one cycle.
  - Latency is therefore `WIDTH`+1 cycles; `busy` is high for exactly `WIDTH`+1 cycles.
- During the `done` cycle of a multi-cycle op, `busy`=0, so a new `start` is accepted on that cycle's edge.
- An MFHI/MFLO issued in the `done` cycle returns the new HI/LO.
- `rst`=1 takes priority over `start` on the same edge.

## Test plan
- **ADD overflow:** ADD a=0x7FFFFFFF, b=1 → one cycle after E0: `done`=1, `result`=0x80000000, `overflow`=1, `busy` never 1. Then SUB a=3, b=5 → `result`=0xFFFFFFFE, `less`=1, `overflow`=0.
- **Count leading bits:**
  - CLZ a=0x00010000 → 15.
  - CLZ a=0 → 32.
  - CLO a=0xFFFFFFFF → 32.
  - SLTU a=1, b=0xFFFFFFFF → `result`=1.
  - SLT with the same operands → `result`=0.
- **Signed multiply, handshake:** MULT a=−3, b=5 → `busy` high 33 cycles, `done` exactly 33 cycles after E0, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. A `start`(ADD) pulsed at cycle 10 is ignored. MFHI issued in the `done` cycle → 0xFFFFFFFF.
- **Divide:**
  - DIVU a=100, b=7 → `lo`=14, `hi`=2.
  - DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIV a=5, b=0 → after 33 cycles `lo`=0xFFFFFFFF, `hi`=5, `div_by_zero`=1 for the `done` cycle only.
- **Reset mid-multiply:** `rst` asserted 10 cycles into a MULTU → next edge `busy`=0 with no `done`, `hi`=`lo`=0. A subsequent MFLO → 0. Repeat with `WIDTH`=16: MULTU 0xFFFF×0xFFFF → `hi`=0xFFFE, `lo`=0x0001, latency 17.
